// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its two requesters (fetch and data
// ports), the shared memory bus and the pipeline control outputs.
// master: the arbiter's view. slave: the view of the surrounding core and bus.
interface mem_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;

    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    logic        stall_o;
    logic        err_o;

    modport master (
        input  if_req_i, if_addr_i,
        output if_data_o, if_ack_o,
        input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        output mem_rdata_o, mem_ack_o,
        output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i,
        output stall_o, err_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        input  if_data_o, if_ack_o,
        output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        input  mem_rdata_o, mem_ack_o,
        input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i,
        input  stall_o, err_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between the instruction fetch port and
// the load/store data port. Fixed data-first priority out of IDLE, then
// alternation on back-to-back completions so neither side starves.
// Optional bus timeout: define ARB_TIMEOUT_EN to enable an 8-bit busy-cycle
// counter that ends a hung transfer with a zero-data ack and an err_o pulse.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no transfer on the bus, bus_req_o low
// IF_BUSY  | fetch transfer presented on the bus
// MEM_BUSY | data transfer presented on the bus
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.master io
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    // The timeout counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        busy;
    logic        timeout;
    logic        done;
    logic        grant_if;
    logic        grant_mem;

    logic        if_ack;
    logic        mem_ack;
    logic [31:0] if_data;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        err;

    assign busy = (state_q != IDLE);
    assign done = busy && (io.bus_ack_i || timeout);

`ifdef ARB_TIMEOUT_EN
    // Number of ack-less busy cycles already completed in this transfer, so
    // the cycle where it equals TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th one.
    logic [7:0] cnt_q;

    assign timeout = busy && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    // Busy-cycle counter: cleared on every grant, counts while the bus is silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (grant_if || grant_mem) begin
            cnt_q <= 8'd0;
        end else if (busy && !io.bus_ack_i) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next state and next bus payload; a grant latches the winner's payload.
    always_comb begin
        state_d     = state_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        grant_if    = 1'b0;
        grant_mem   = 1'b0;

        case (state_q)
            IDLE: begin
                if (io.mem_req_i)     grant_mem = 1'b1;
                else if (io.if_req_i) grant_if  = 1'b1;
            end
            MEM_BUSY: begin
                if (done) begin
                    if (io.if_req_i)       grant_if  = 1'b1;
                    else if (io.mem_req_i) grant_mem = 1'b1;
                    else                   state_d   = IDLE;
                end
            end
            IF_BUSY: begin
                if (done) begin
                    if (io.mem_req_i)     grant_mem = 1'b1;
                    else if (io.if_req_i) grant_if  = 1'b1;
                    else                  state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_mem) begin
            state_d     = MEM_BUSY;
            bus_we_d    = io.mem_we_i;
            bus_sel_d   = io.mem_sel_i;
            bus_addr_d  = io.mem_addr_i;
            bus_wdata_d = io.mem_wdata_i;
        end else if (grant_if) begin
            state_d     = IF_BUSY;
            bus_we_d    = 1'b0;
            bus_sel_d   = 4'hF;
            bus_addr_d  = io.if_addr_i;
            bus_wdata_d = 32'd0;
        end

        bus_req_d = (state_d != IDLE);
    end

    // State and bus output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'h0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    // Same-cycle acks to the owning requester, stall and error; all quiet in reset.
    always_comb begin
        if_ack    = 1'b0;
        mem_ack   = 1'b0;
        if_data   = 32'd0;
        mem_rdata = 32'd0;
        stall     = 1'b0;
        err       = 1'b0;
        if (!rst) begin
            if (state_q == IF_BUSY && done) begin
                if_ack  = 1'b1;
                if_data = io.bus_ack_i ? io.bus_rdata_i : 32'd0;
            end
            if (state_q == MEM_BUSY && done) begin
                mem_ack   = 1'b1;
                mem_rdata = io.bus_ack_i ? io.bus_rdata_i : 32'd0;
            end
            // A real ack in the timeout cycle wins and is not an error.
            err   = timeout && !io.bus_ack_i;
            stall = (io.if_req_i && !if_ack) || (io.mem_req_i && !mem_ack);
        end
    end

    assign io.if_ack_o    = if_ack;
    assign io.if_data_o   = if_data;
    assign io.mem_ack_o   = mem_ack;
    assign io.mem_rdata_o = mem_rdata;
    assign io.stall_o     = stall;
    assign io.err_o       = err;
    assign io.bus_req_o   = bus_req_q;
    assign io.bus_we_o    = bus_we_q;
    assign io.bus_sel_o   = bus_sel_q;
    assign io.bus_addr_o  = bus_addr_q;
    assign io.bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change 1 ns after the rising edge,
// outputs are checked 1 ns later. Build with ARB_TIMEOUT_EN defined to
// exercise the timeout path (TIMEOUT_CYCLES = 4), without it for the
// indefinite-wait path.
module tb_mem_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    mem_arbiter_if bus_if ();

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst                = 1'b1;
        bus_if.if_req_i    = 1'b0;
        bus_if.if_addr_i   = 32'd0;
        bus_if.mem_req_i   = 1'b0;
        bus_if.mem_we_i    = 1'b0;
        bus_if.mem_sel_i   = 4'h0;
        bus_if.mem_addr_i  = 32'd0;
        bus_if.mem_wdata_i = 32'd0;
        bus_if.bus_rdata_i = 32'd0;
        bus_if.bus_ack_i   = 1'b0;

        // Reset: registers cleared, combinational outputs quiet even with a request.
        tick();
        bus_if.if_req_i = 1'b1;
        #1;
        check("rst_stall",    32'(bus_if.stall_o),   32'd0);
        check("rst_if_ack",   32'(bus_if.if_ack_o),  32'd0);
        check("rst_mem_ack",  32'(bus_if.mem_ack_o), 32'd0);
        check("rst_if_data",  bus_if.if_data_o,      32'd0);
        check("rst_err",      32'(bus_if.err_o),     32'd0);
        check("rst_bus_req",  32'(bus_if.bus_req_o), 32'd0);
        check("rst_bus_sel",  32'(bus_if.bus_sel_o), 32'd0);
        check("rst_bus_addr", bus_if.bus_addr_o,     32'd0);

        // Single fetch, ack after two busy cycles; stall high for three cycles.
        tick();
        rst              = 1'b0;
        bus_if.if_addr_i = 32'h0000_0100;
        #1;
        check("f1_stall_a",   32'(bus_if.stall_o),   32'd1);
        check("f1_bus_req_a", 32'(bus_if.bus_req_o), 32'd0);
        tick();
        check("f1_bus_req",   32'(bus_if.bus_req_o), 32'd1);
        check("f1_bus_addr",  bus_if.bus_addr_o,     32'h0000_0100);
        check("f1_bus_sel",   32'(bus_if.bus_sel_o), 32'hF);
        check("f1_bus_we",    32'(bus_if.bus_we_o),  32'd0);
        check("f1_bus_wdata", bus_if.bus_wdata_o,    32'd0);
        check("f1_stall_b",   32'(bus_if.stall_o),   32'd1);
        check("f1_if_ack_b",  32'(bus_if.if_ack_o),  32'd0);
        tick();
        check("f1_stall_c",   32'(bus_if.stall_o),   32'd1);
        check("f1_if_ack_c",  32'(bus_if.if_ack_o),  32'd0);
        tick();
        bus_if.bus_ack_i   = 1'b1;
        bus_if.bus_rdata_i = 32'h2402_0005;
        #1;
        check("f1_if_ack",    32'(bus_if.if_ack_o),  32'd1);
        check("f1_if_data",   bus_if.if_data_o,      32'h2402_0005);
        check("f1_stall_d",   32'(bus_if.stall_o),   32'd0);
        check("f1_mem_ack",   32'(bus_if.mem_ack_o), 32'd0);
        check("f1_mem_rdata", bus_if.mem_rdata_o,    32'd0);
        // Request was still high at completion, so the fetch is granted again.
        tick();
        bus_if.if_req_i    = 1'b0;
        bus_if.bus_rdata_i = 32'h0BAD_0BAD;
        #1;
        check("f1_regrant",   32'(bus_if.bus_req_o), 32'd1);
        check("f1_if_ack2",   32'(bus_if.if_ack_o),  32'd1);
        // Idle with bus_ack_i high: ignored.
        tick();
        check("idle_bus_req", 32'(bus_if.bus_req_o), 32'd0);
        check("idle_if_ack",  32'(bus_if.if_ack_o),  32'd0);
        check("idle_mem_ack", 32'(bus_if.mem_ack_o), 32'd0);
        check("idle_if_data", bus_if.if_data_o,      32'd0);
        tick();
        bus_if.bus_ack_i = 1'b0;
        #1;
        check("idle_stays",   32'(bus_if.bus_req_o), 32'd0);

        // Simultaneous requests from IDLE: data first, fetch right after.
        bus_if.if_req_i    = 1'b1;
        bus_if.if_addr_i   = 32'h0000_0200;
        bus_if.mem_req_i   = 1'b1;
        bus_if.mem_we_i    = 1'b1;
        bus_if.mem_sel_i   = 4'b0011;
        bus_if.mem_addr_i  = 32'h8000_0004;
        bus_if.mem_wdata_i = 32'hDEAD_BEEF;
        #1;
        check("both_stall",   32'(bus_if.stall_o),   32'd1);
        tick();
        bus_if.bus_ack_i   = 1'b1;
        bus_if.bus_rdata_i = 32'h1111_2222;
        #1;
        check("both_m_we",    32'(bus_if.bus_we_o),  32'd1);
        check("both_m_sel",   32'(bus_if.bus_sel_o), 32'h3);
        check("both_m_addr",  bus_if.bus_addr_o,     32'h8000_0004);
        check("both_m_wdata", bus_if.bus_wdata_o,    32'hDEAD_BEEF);
        check("both_m_ack",   32'(bus_if.mem_ack_o), 32'd1);
        check("both_m_rdata", bus_if.mem_rdata_o,    32'h1111_2222);
        check("both_m_ifack", 32'(bus_if.if_ack_o),  32'd0);
        check("both_m_stall", 32'(bus_if.stall_o),   32'd1);
        tick();
        bus_if.mem_req_i = 1'b0;
        #1;
        check("both_i_req",   32'(bus_if.bus_req_o), 32'd1);
        check("both_i_addr",  bus_if.bus_addr_o,     32'h0000_0200);
        check("both_i_we",    32'(bus_if.bus_we_o),  32'd0);
        check("both_i_sel",   32'(bus_if.bus_sel_o), 32'hF);
        check("both_i_wdata", bus_if.bus_wdata_o,    32'd0);
        check("both_i_ack",   32'(bus_if.if_ack_o),  32'd1);
        check("both_i_mack",  32'(bus_if.mem_ack_o), 32'd0);
        tick();
        bus_if.if_req_i = 1'b0;
        #1;
        check("both_i_ack2",  32'(bus_if.if_ack_o),  32'd1);
        tick();
        bus_if.bus_ack_i = 1'b0;
        #1;
        check("both_idle",    32'(bus_if.bus_req_o), 32'd0);

        // Both held for six back-to-back transfers: MEM, IF, MEM, IF, MEM, IF.
        bus_if.if_req_i    = 1'b1;
        bus_if.if_addr_i   = 32'h0000_0300;
        bus_if.mem_req_i   = 1'b1;
        bus_if.mem_we_i    = 1'b1;
        bus_if.mem_sel_i   = 4'b1100;
        bus_if.mem_addr_i  = 32'h8000_0010;
        bus_if.mem_wdata_i = 32'h5555_AAAA;
        tick();
        bus_if.bus_ack_i   = 1'b1;
        bus_if.bus_rdata_i = 32'h0000_0042;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k % 2 == 0) begin
                check($sformatf("alt%0d_addr", k), bus_if.bus_addr_o,     32'h8000_0010);
                check($sformatf("alt%0d_mack", k), 32'(bus_if.mem_ack_o), 32'd1);
                check($sformatf("alt%0d_iack", k), 32'(bus_if.if_ack_o),  32'd0);
            end else begin
                check($sformatf("alt%0d_addr", k), bus_if.bus_addr_o,     32'h0000_0300);
                check($sformatf("alt%0d_mack", k), 32'(bus_if.mem_ack_o), 32'd0);
                check($sformatf("alt%0d_iack", k), 32'(bus_if.if_ack_o),  32'd1);
            end
            tick();
        end
        bus_if.if_req_i  = 1'b0;
        bus_if.mem_req_i = 1'b0;
        #1;
        check("alt6_addr",    bus_if.bus_addr_o,     32'h8000_0010);
        check("alt6_mack",    32'(bus_if.mem_ack_o), 32'd1);
        tick();
        bus_if.bus_ack_i = 1'b0;
        #1;
        check("alt_idle",     32'(bus_if.bus_req_o), 32'd0);

        // Reset pulse mid MEM_BUSY, then a late ack: ignored.
        bus_if.mem_req_i   = 1'b1;
        bus_if.mem_we_i    = 1'b0;
        bus_if.mem_sel_i   = 4'hF;
        bus_if.mem_addr_i  = 32'h0000_0040;
        bus_if.mem_wdata_i = 32'd0;
        tick();
        check("rp_bus_req",   32'(bus_if.bus_req_o), 32'd1);
        check("rp_bus_addr",  bus_if.bus_addr_o,     32'h0000_0040);
        rst = 1'b1;
        #1;
        check("rp_mack_rst",  32'(bus_if.mem_ack_o), 32'd0);
        check("rp_stall_rst", 32'(bus_if.stall_o),   32'd0);
        tick();
        rst                = 1'b0;
        bus_if.mem_req_i   = 1'b0;
        bus_if.bus_ack_i   = 1'b1;
        bus_if.bus_rdata_i = 32'hCAFE_0001;
        #1;
        check("rp_mack_late", 32'(bus_if.mem_ack_o), 32'd0);
        check("rp_rdata",     bus_if.mem_rdata_o,    32'd0);
        check("rp_bus_req0",  32'(bus_if.bus_req_o), 32'd0);
        tick();
        bus_if.bus_ack_i = 1'b0;
        #1;
        check("rp_idle",      32'(bus_if.bus_req_o), 32'd0);

`ifdef ARB_TIMEOUT_EN
        // No bus ack: the 4th busy cycle ends the fetch with zero data and err.
        bus_if.if_req_i  = 1'b1;
        bus_if.if_addr_i = 32'h0000_0500;
        tick();
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("to_c%0d_iack", c), 32'(bus_if.if_ack_o), 32'd0);
            check($sformatf("to_c%0d_err",  c), 32'(bus_if.err_o),    32'd0);
            check($sformatf("to_c%0d_stall", c), 32'(bus_if.stall_o), 32'd1);
            tick();
        end
        check("to_iack",      32'(bus_if.if_ack_o),  32'd1);
        check("to_idata",     bus_if.if_data_o,      32'd0);
        check("to_err",       32'(bus_if.err_o),     32'd1);
        check("to_addr",      bus_if.bus_addr_o,     32'h0000_0500);
        // Held request is re-granted with a fresh count.
        tick();
        bus_if.if_req_i = 1'b0;
        #1;
        check("to_err_pulse", 32'(bus_if.err_o),     32'd0);
        check("to_regrant",   32'(bus_if.bus_req_o), 32'd1);
        tick();
        tick();
        tick();
        bus_if.bus_ack_i   = 1'b1;
        bus_if.bus_rdata_i = 32'h7777_0001;
        #1;
        check("tack_err",     32'(bus_if.err_o),     32'd0);
        check("tack_iack",    32'(bus_if.if_ack_o),  32'd1);
        check("tack_idata",   bus_if.if_data_o,      32'h7777_0001);
        tick();
        bus_if.bus_ack_i = 1'b0;
        #1;
        check("tack_idle",    32'(bus_if.bus_req_o), 32'd0);
        check("tack_err_idl", 32'(bus_if.err_o),     32'd0);
`else
        // No bus ack for 300 cycles: still stalled, never an error.
        bus_if.if_req_i  = 1'b1;
        bus_if.if_addr_i = 32'h0000_0600;
        tick();
        for (int c = 0; c < 300; c++) begin
            check($sformatf("wait%0d_stall", c), 32'(bus_if.stall_o), 32'd1);
            check($sformatf("wait%0d_err",   c), 32'(bus_if.err_o),   32'd0);
            tick();
        end
        bus_if.bus_ack_i   = 1'b1;
        bus_if.bus_rdata_i = 32'h1234_5678;
        #1;
        check("wait_iack",    32'(bus_if.if_ack_o),  32'd1);
        check("wait_idata",   bus_if.if_data_o,      32'h1234_5678);
        check("wait_err",     32'(bus_if.err_o),     32'd0);
        tick();
        bus_if.if_req_i = 1'b0;
        #1;
        check("wait_iack2",   32'(bus_if.if_ack_o),  32'd1);
        tick();
        bus_if.bus_ack_i = 1'b0;
        #1;
        check("wait_idle",    32'(bus_if.bus_req_o), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 The block SHALL have the fetch port: if_req_i  input  1  fetch request; if_addr_i  input  32  fetch address; if_data_o  output  32  fetched word; if_ack_o  output  1  fetch done.
REQ-003 The block SHALL have the data port: mem_req_i  input  1  request; mem_we_i  input  1  write; mem_sel_i  input  4  byte enables; mem_addr_i  input  32  address; mem_wdata_i  input  32  write data; mem_rdata_o  output  32  read data; mem_ack_o  output  1  done.
REQ-004 The block SHALL have the shared bus port: bus_req_o  output  1  bus request; bus_we_o  output  1  write; bus_sel_o  output  4  byte enables; bus_addr_o  output  32  address; bus_wdata_o  output  32  write data; bus_rdata_i  input  32  read data; bus_ack_i  input  1  transfer done.
REQ-005 The block SHALL have the pipeline control port: stall_o  output  1  freeze pc and pipeline registers; err_o  output  1  one-cycle bus-timeout pulse.
REQ-006 The block SHALL have the parameter TIMEOUT_CYCLES, default 255, giving the maximum number of busy cycles without bus_ack_i.

Function
REQ-007 The FSM SHALL have the states IDLE, IF_BUSY and MEM_BUSY, with state, counter and all bus_* outputs registered.
REQ-008 In IDLE with mem_req_i=1, the FSM SHALL go to MEM_BUSY next cycle and latch mem_we/sel/addr/wdata onto bus_*; with only if_req_i=1 it SHALL go to IF_BUSY with bus_we_o=0, bus_sel_o=4'hF, bus_addr_o=if_addr_i, bus_wdata_o=0; the first grant is one cycle after the request.
REQ-009 bus_req_o SHALL be 1 exactly in IF_BUSY and MEM_BUSY, and bus_* SHALL be held stable until bus_ack_i.
REQ-010 In a busy state with bus_ack_i=1, the matching ack SHALL be asserted combinationally in the same cycle, with the matching rdata output = bus_rdata_i; the non-matching ack SHALL stay 0.
REQ-011 if_data_o and mem_rdata_o SHALL be 0 whenever their ack is 0.
REQ-012 On completion in MEM_BUSY, the FSM SHALL go to IF_BUSY if if_req_i=1, else to MEM_BUSY (new latch) if mem_req_i=1, else to IDLE.
REQ-013 On completion in IF_BUSY, the FSM SHALL go to MEM_BUSY if mem_req_i=1, else to IF_BUSY if if_req_i=1, else to IDLE; this gives alternation when both are pending, with no starvation.
REQ-014 Requesters SHALL hold req and payload stable until ack, and the block SHALL NOT re-sample the payload while busy.
REQ-015 stall_o SHALL equal (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o), combinationally.
REQ-016 bus_ack_i received in IDLE SHALL be ignored.
REQ-017 A request deasserted before grant SHALL be dropped silently.

Reset
REQ-018 When rst=1 at a clock edge, the block SHALL set state=IDLE, bus_req_o=0, bus_we_o=0, bus_sel_o=0, bus_addr_o=0, bus_wdata_o=0 and timeout counter=0.
REQ-019 While rst=1, if_ack_o, mem_ack_o, if_data_o, mem_rdata_o, stall_o and err_o SHALL all be 0.
REQ-020 A reset during a busy state SHALL abandon the transfer with no ack generated, and any late bus_ack_i SHALL be ignored per REQ-016.

Configuration
REQ-021 With ARB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entering a busy state and increment each busy cycle without bus_ack_i.
REQ-022 With ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL in that cycle assert the owner's ack with rdata=0 and err_o=1 for one cycle, then follow REQ-012/013 as a completion.
REQ-023 With ARB_TIMEOUT_EN defined, bus_ack_i and timeout in the same cycle SHALL be treated as a normal ack with err_o=0.
REQ-024 Without ARB_TIMEOUT_EN, no counter SHALL exist, busy states SHALL wait indefinitely, and err_o SHALL be tied to 0.

Verification
REQ-025 The bench SHALL check: if_req_i=1, if_addr_i=32'h0000_0100, bus_ack_i after 2 cycles with bus_rdata_i=32'h2402_0005 -> bus_addr_o=32'h100, bus_sel_o=4'hF, if_ack_o=1 with if_data_o=32'h2402_0005, stall_o high 3 cycles.
REQ-026 The bench SHALL check: if_req_i and mem_req_i (write, sel 4'b0011, addr 32'h8000_0004, wdata 32'hDEAD_BEEF) asserted together in IDLE -> MEM granted first with bus_we_o=1, then IF, with no idle cycle between.
REQ-027 The bench SHALL check: both requests held continuously for 6 transfers -> grant order MEM, IF, MEM, IF, MEM, IF.
REQ-028 The bench SHALL check: rst pulsed 1 cycle during MEM_BUSY, then bus_ack_i=1 -> mem_ack_o stays 0, bus_req_o=0, state IDLE.
REQ-029 The bench SHALL check, with ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=4: bus_ack_i never asserted -> at the 4th busy cycle if_ack_o=1, if_data_o=0, err_o=1 for one cycle.
REQ-030 The bench SHALL check, with ARB_TIMEOUT_EN not defined: bus_ack_i withheld 300 cycles -> stall_o stays 1 and err_o stays 0 throughout.
